ifetch_line_responder: RTL and testbench
========================================

Name: ifetch_line_responder

Overview:
- Responder side of the fetch request interface: accepts the fetch PC and valid from the PC update stage, returns one instruction word per request with a one-cycle `imem_resp` pulse.
- Holds a single cacheline buffer (tag + valid). Hits return on the next cycle. Misses issue a line read to the memory side and respond when the fill completes.
- A flush (branch mispredict) cancels the pending response. An in-flight memory read is always drained, never abandoned.

Parameters:
- LINE_WORDS, 8, 32-bit words per cacheline; power of two, at least 2.
- RESET_TAG_VALID, 0, line buffer valid bit value at reset (must stay 0 in product builds).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- fetch_addr  in  32  fetch PC; bits [1:0] ignored
- fetch_v  in  1  fetch request valid this cycle
- flush  in  1  mispredict; kill the outstanding request
- imem_resp  out  1  one-cycle pulse: `imem_rdata` valid for the last accepted request
- imem_rdata  out  32  instruction word
- busy  out  1  high in MISS/DRAIN; requests are not accepted
- mem_addr  out  32  line-aligned read address
- mem_read  out  1  line read request, level
- mem_rdata  in  32*LINE_WORDS  line data, valid with `mem_resp`
- mem_resp  in  1  one-cycle pulse completing the read

Behaviour:
- Reset (async, any state): state=IDLE, line_valid=0, imem_resp=0, imem_rdata=0, mem_read=0, mem_addr=0, busy=0.
- Address split: OFF=log2(LINE_WORDS)+2.
  - tag = fetch_addr[31:OFF]
  - word index = fetch_addr[OFF-1:2]
  - mem_addr = {req_tag, OFF'b0}
- Outputs `imem_resp`/`imem_rdata` are registered. `mem_read`, `mem_addr` and `busy` are decoded from state and registers only, never from inputs.
- IDLE:
  - fetch_v & ~flush & line_valid & tag match: next cycle imem_resp=1, imem_rdata = buffer[index]. Throughput is one request per cycle; back-to-back hits are allowed.
  - fetch_v & ~flush & miss: latch req_addr → MISS. imem_resp=0 next cycle.
  - flush, or ~fetch_v: no capture; imem_resp=0 next cycle.
- MISS:
  - mem_read=1, mem_addr held stable until and including the mem_resp cycle. fetch_v is ignored.
  - mem_resp & ~flush: write line, set tag, line_valid=1. Next cycle imem_resp=1, imem_rdata = mem_rdata word[req index]. → IDLE.
  - flush & ~mem_resp: → DRAIN.
  - flush & mem_resp (same cycle): fill the line, no response, → IDLE.
- DRAIN:
  - mem_read=1, same mem_addr. fetch_v is ignored; flush has no further effect.
  - mem_resp: fill the line (data is architecturally valid), no imem_resp, → IDLE.
- Flush in the same cycle a registered imem_resp is high: that pulse still appears, because the requester gives mispredict priority. The following cycle imem_resp=0.
- imem_rdata holds its last value when imem_resp=0.
- Line fill happens on the mem_resp edge, so a request in IDLE on the very next cycle to the same line hits.
- Never more than one outstanding memory read.
- Reset asserted mid-MISS/DRAIN: immediately IDLE, mem_read=0. The memory model must also be reset.

Decomposition:
- Shared package `rv32i_types`:
  - enum ifetch_state_t {IFETCH_IDLE, IFETCH_MISS, IFETCH_DRAIN}
  - constant PC_RESET = 32'h60000000
- Line buffer storage, tag compare and word select fit as sub-module `ifetch_line_buf` (write-enable, tag, line in; hit, word out).
- FSM and response registers stay in the top.

Test Plan:
- Reset, fetch_addr=0x60000000 fetch_v=1 → mem_read=1 mem_addr=0x60000000 next cycle. mem_resp with word0=0x00000013 → imem_resp=1 imem_rdata=0x00000013 one cycle later, busy=0.
- After that fill, fetch 0x60000004, 0x60000008, 0x6000001C on consecutive cycles → three consecutive imem_resp pulses returning words 1, 2, 7. No mem_read.
- Fetch 0x60000020 (miss), pulse flush two cycles later, mem_resp three cycles later → no imem_resp. Then fetch 0x60000024 → hit, word1 of the new line, no mem_read.
- Miss on 0x60001000 with flush and mem_resp in the same cycle → no imem_resp, state IDLE. Then 0x60001000 hits next cycle.
- Hit request with flush asserted the same cycle → no imem_resp the following cycle.
- Assert rst during MISS → mem_read=0 and imem_resp=0 immediately. After release, fetch 0x60000000 misses (line_valid cleared).

Source files
------------

// File: rtl/ifetch_line_responder_pkg.sv
// Shared fetch-side types: responder FSM states and the architectural reset PC.
package rv32i_types;

    typedef enum logic [1:0] {
        IFETCH_IDLE,
        IFETCH_MISS,
        IFETCH_DRAIN
    } ifetch_state_t;

    localparam logic [31:0] PC_RESET = 32'h6000_0000;

endpackage

// File: rtl/ifetch_line_responder_line_buf.sv
// Single-line instruction buffer: tag/valid, full-line write, tag compare and word select.
module ifetch_line_buf #(
    parameter int LINE_WORDS      = 8,
    parameter bit RESET_TAG_VALID = 1'b0,
    parameter int TAG_W           = 27,
    parameter int IDX_W           = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [TAG_W-1:0]        wr_tag,
    input  logic [32*LINE_WORDS-1:0] wr_line,
    input  logic [TAG_W-1:0]        rd_tag,
    input  logic [IDX_W-1:0]        rd_index,
    output logic                    hit,
    output logic [31:0]             word
);

    logic                     line_valid;
    logic [TAG_W-1:0]         line_tag;
    logic [32*LINE_WORDS-1:0] line_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid <= RESET_TAG_VALID;
            line_tag   <= '0;
            line_data  <= '0;
        end else if (we) begin
            line_valid <= 1'b1;
            line_tag   <= wr_tag;
            line_data  <= wr_line;
        end
    end

    assign hit  = line_valid && (line_tag == rd_tag);
    assign word = line_data[32*int'(rd_index) +: 32];

endmodule

// File: rtl/ifetch_line_responder.sv
// Fetch responder: one-line buffer, hits answer next cycle, misses fetch a whole line.
module ifetch_line_responder
    import rv32i_types::*;
#(
    parameter int LINE_WORDS      = 8,
    parameter bit RESET_TAG_VALID = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              fetch_addr,
    input  logic                     fetch_v,
    input  logic                     flush,
    output logic                     imem_resp,
    output logic [31:0]              imem_rdata,
    output logic                     busy,
    output logic [31:0]              mem_addr,
    output logic                     mem_read,
    input  logic [32*LINE_WORDS-1:0] mem_rdata,
    input  logic                     mem_resp
);

    localparam int OFF   = $clog2(LINE_WORDS) + 2;
    localparam int TAG_W = 32 - OFF;
    localparam int IDX_W = OFF - 2;

    ifetch_state_t    state;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_index;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] fetch_index;
    logic             buf_hit;
    logic [31:0]      buf_word;
    logic             fill_en;
    logic [31:0]      fill_word;
    logic             unused_byte_bits;

    assign fetch_tag        = fetch_addr[31:OFF];
    assign fetch_index      = fetch_addr[OFF-1:2];
    assign unused_byte_bits = ^fetch_addr[1:0];

    // A returning line is always written, even after a flush, since its data is still valid.
    assign fill_en   = (state != IFETCH_IDLE) && mem_resp;
    assign fill_word = mem_rdata[32*int'(req_index) +: 32];

    ifetch_line_buf #(
        .LINE_WORDS      (LINE_WORDS),
        .RESET_TAG_VALID (RESET_TAG_VALID),
        .TAG_W           (TAG_W),
        .IDX_W           (IDX_W)
    ) u_line_buf (
        .clk      (clk),
        .rst      (rst),
        .we       (fill_en),
        .wr_tag   (req_tag),
        .wr_line  (mem_rdata),
        .rd_tag   (fetch_tag),
        .rd_index (fetch_index),
        .hit      (buf_hit),
        .word     (buf_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IFETCH_IDLE;
            req_tag    <= '0;
            req_index  <= '0;
            imem_resp  <= 1'b0;
            imem_rdata <= '0;
        end else begin
            imem_resp <= 1'b0;
            case (state)
                IFETCH_IDLE: begin
                    if (fetch_v && !flush) begin
                        if (buf_hit) begin
                            imem_resp  <= 1'b1;
                            imem_rdata <= buf_word;
                        end else begin
                            req_tag   <= fetch_tag;
                            req_index <= fetch_index;
                            state     <= IFETCH_MISS;
                        end
                    end
                end
                IFETCH_MISS: begin
                    if (mem_resp) begin
                        state <= IFETCH_IDLE;
                        if (!flush) begin
                            imem_resp  <= 1'b1;
                            imem_rdata <= fill_word;
                        end
                    end else if (flush) begin
                        state <= IFETCH_DRAIN;
                    end
                end
                IFETCH_DRAIN: begin
                    if (mem_resp) begin
                        state <= IFETCH_IDLE;
                    end
                end
                default: state <= IFETCH_IDLE;
            endcase
        end
    end

    assign busy     = (state != IFETCH_IDLE);
    assign mem_read = busy;
    assign mem_addr = {req_tag, {OFF{1'b0}}};

endmodule

// File: tb/tb_ifetch_line_responder.sv
// Randomized and directed bench for ifetch_line_responder against a line-level reference model.
module tb_ifetch_line_responder;

    localparam int LW = 8;
    localparam logic [31:0] PC0 = 32'h6000_0000;

    logic            clk;
    logic            rst;
    logic [31:0]     fetch_addr;
    logic            fetch_v;
    logic            flush;
    logic            imem_resp;
    logic [31:0]     imem_rdata;
    logic            busy;
    logic [31:0]     mem_addr;
    logic            mem_read;
    logic [32*LW-1:0] mem_rdata;
    logic            mem_resp;

    int checks;
    int failures;

    // Reference model: what the requester and memory observe, not how the RTL encodes it.
    bit          m_line_valid;
    logic [31:0] m_line_base;
    logic [31:0] m_line_words [LW];
    bit          m_pending;
    bit          m_killed;
    logic [31:0] m_pend_base;
    int          m_pend_idx;
    bit          m_resp;
    logic [31:0] m_rdata;

    ifetch_line_responder #(
        .LINE_WORDS      (LW),
        .RESET_TAG_VALID (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_addr (fetch_addr),
        .fetch_v    (fetch_v),
        .flush      (flush),
        .imem_resp  (imem_resp),
        .imem_rdata (imem_rdata),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a - PC0) * 32'h9E37_79B1 + 32'h13;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_line_valid = 0;
        m_line_base  = '0;
        m_pending    = 0;
        m_killed     = 0;
        m_pend_base  = '0;
        m_pend_idx   = 0;
        m_resp       = 0;
        m_rdata      = '0;
        for (int i = 0; i < LW; i++) m_line_words[i] = '0;
    endtask

    task automatic checkState();
        checkOutput("imem_resp", {31'b0, imem_resp}, {31'b0, m_resp});
        checkOutput("imem_rdata", imem_rdata, m_rdata);
        checkOutput("busy", {31'b0, busy}, {31'b0, m_pending});
        checkOutput("mem_read", {31'b0, mem_read}, {31'b0, m_pending});
        if (m_pending) checkOutput("mem_addr", mem_addr, m_pend_base);
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model, cross the edge.
    task automatic applyStimulus(input bit fv, input logic [31:0] addr, input bit fl, input bit mr);
        logic [31:0] base;
        int          idx;
        checkState();
        fetch_v    = fv;
        fetch_addr = addr;
        flush      = fl;
        mem_resp   = mr;
        for (int i = 0; i < LW; i++)
            mem_rdata[32*i +: 32] = mr ? mem_word(m_pend_base + 32'(4*i)) : $urandom;
        base = addr & ~32'(4*LW - 1);
        idx  = int'((addr >> 2) & 32'(LW - 1));
        m_resp = 0;
        if (!m_pending) begin
            if (fv && !fl) begin
                if (m_line_valid && base == m_line_base) begin
                    m_resp  = 1;
                    m_rdata = m_line_words[idx];
                end else begin
                    m_pending   = 1;
                    m_killed    = 0;
                    m_pend_base = base;
                    m_pend_idx  = idx;
                end
            end
        end else if (mr) begin
            m_line_valid = 1;
            m_line_base  = m_pend_base;
            for (int i = 0; i < LW; i++) m_line_words[i] = mem_word(m_pend_base + 32'(4*i));
            if (!m_killed && !fl) begin
                m_resp  = 1;
                m_rdata = m_line_words[m_pend_idx];
            end
            m_pending = 0;
        end else if (fl) begin
            m_killed = 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        fetch_addr = '0;
        fetch_v    = 1'b0;
        flush      = 1'b0;
        mem_resp   = 1'b0;
        mem_rdata  = '0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkState();
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;

        // Cold miss on the reset PC, then fill with word0 = NOP
        applyStimulus(1, PC0, 0, 0);
        checkOutput("miss_mem_addr", mem_addr, PC0);
        applyStimulus(0, 32'h0, 0, 0);
        applyStimulus(0, 32'h0, 0, 1);
        checkOutput("first_word", imem_rdata, 32'h0000_0013);

        // Back-to-back hits in the filled line
        applyStimulus(1, PC0 + 32'h04, 0, 0);
        applyStimulus(1, PC0 + 32'h08, 0, 0);
        applyStimulus(1, PC0 + 32'h1C, 0, 0);
        checkOutput("hit_word7", imem_rdata, mem_word(PC0 + 32'h1C));
        applyStimulus(0, 32'h0, 0, 0);

        // Miss, flush two cycles later, drained fill, then hit in the new line
        applyStimulus(1, PC0 + 32'h20, 0, 0);
        applyStimulus(0, 32'h0, 0, 0);
        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1);
        applyStimulus(1, PC0 + 32'h24, 0, 0);
        applyStimulus(0, 32'h0, 0, 0);

        // Flush coincident with mem_resp, then the same address hits
        applyStimulus(1, PC0 + 32'h1000, 0, 0);
        applyStimulus(0, 32'h0, 1, 1);
        applyStimulus(1, PC0 + 32'h1000, 0, 0);

        // Flush on a hit request; flush while a response pulse is high
        applyStimulus(1, PC0 + 32'h1004, 1, 0);
        applyStimulus(1, PC0 + 32'h1008, 0, 0);
        applyStimulus(1, PC0 + 32'h100C, 1, 0);
        applyStimulus(0, 32'h0, 0, 0);

        // Reset asserted in the middle of a miss
        applyStimulus(1, PC0, 0, 0);
        checkState();
        rst = 1'b1;
        #1;
        checkOutput("rst_mem_read", {31'b0, mem_read}, 32'h0);
        checkOutput("rst_imem_resp", {31'b0, imem_resp}, 32'h0);
        modelReset();
        mem_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, PC0, 0, 0);
        checkOutput("post_rst_miss", {31'b0, mem_read}, 32'h1);
        applyStimulus(0, 32'h0, 0, 1);

        // Random traffic over a handful of lines with random flushes and memory latency
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            bit          fv;
            bit          fl;
            bit          mr;
            a  = PC0 + 32'(32 * $urandom_range(0, 3)) + 32'($urandom_range(0, 31));
            fv = ($urandom_range(0, 9) < 7);
            fl = ($urandom_range(0, 9) < 1);
            mr = m_pending && ($urandom_range(0, 9) < 4);
            applyStimulus(fv, a, fl, mr);
        end
        checkState();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
